// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared FIFO defaults; upstream FSM thresholds (5 and 2) assume FIFO_DEPTH
package sync_fifo_pkg;
  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_DEPTH = 8;
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_WIDTH register array, sync write, async read, no reset
module fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data, live count and sticky error flags
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_WIDTH-1:0]  fifo_words,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wptr, rptr;
  logic [DATA_WIDTH-1:0] rdata;
  logic wa, ra;
  assign full = fifo_words == CNT_WIDTH'(DEPTH);
  assign empty = fifo_words == '0;
  // a read frees the slot in the same edge, so a full FIFO still takes a write alongside it
  assign wa = wr_en && (!full || rd_en);
  assign ra = rd_en && !empty;
  fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(clk), .we(wa), .waddr(wptr), .wdata(data_in), .raddr(rptr), .rdata(rdata)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      fifo_words <= '0;
      data_out <= '0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wa) wptr <= wptr + 1'b1;
      if (ra) rptr <= rptr + 1'b1;
      if (ra) data_out <= rdata;
      rd_valid <= ra;
      if (wa != ra) fifo_words <= wa ? fifo_words + 1'b1 : fifo_words - 1'b1;
      overflow <= (wr_en && !wa) || (overflow && !clr_err);
      underflow <= (rd_en && !ra) || (underflow && !clr_err);
    end
endmodule
